// File: rtl/fifo_stream_bridge_pkg.sv
// Shared types and helpers for the FIFO-to-FIFO sample reduction bridge.
package fifo_stream_bridge_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_PEAK = 2'd1,
    MODE_AVG  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CAP   = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  // The accumulator carries max_log2 guard bits so a full average never overflows.
  function automatic int acc_width(input int data_w, input int max_log2);
    return data_w + max_log2;
  endfunction

  // Raw mode code 3 behaves exactly like pass.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_PEAK;
      2'd2:    return MODE_AVG;
      default: return MODE_PASS;
    endcase
  endfunction

endpackage

// File: rtl/fifo_stream_bridge_if.sv
// FIFO read port (input sample FIFO) and FIFO write port (VGA FIFO) seen by the bridge.
interface fifo_stream_bridge_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_q;
  logic              in_rdempty;
  logic              in_rdreq;
  logic [DATA_W-1:0] out_data;
  logic              out_full;
  logic              out_wrreq;

  modport master (
    input  in_q, in_rdempty, out_full,
    output in_rdreq, out_data, out_wrreq
  );

  modport slave (
    output in_q, in_rdempty, out_full,
    input  in_rdreq, out_data, out_wrreq
  );
endinterface

// File: rtl/fifo_stream_bridge_lane.sv
// One channel's reduction register: holds the last sample (pass), the running
// saturated magnitude maximum (peak) or the signed running sum (average).
module fifo_stream_bridge_lane
  import fifo_stream_bridge_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_LOG2 = 4,
  parameter int LOG_W    = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cap_en_i,
  input  logic              clear_i,
  input  mode_e             mode_i,
  input  logic [LOG_W-1:0]  shift_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int ACC_W = acc_width(DATA_W, MAX_LOG2);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [DATA_W-1:0] mag;
  logic signed [ACC_W-1:0] sample_ext, mag_ext;

  // Magnitude of the incoming sample, saturating the most negative code, plus sign/zero extensions.
  always_comb begin
    if (sample_i == MOST_NEG) begin
      mag = MOST_POS;
    end else if (sample_i[DATA_W-1]) begin
      mag = -sample_i;
    end else begin
      mag = sample_i;
    end
    sample_ext = {{MAX_LOG2{sample_i[DATA_W-1]}}, sample_i};
    mag_ext    = {{MAX_LOG2{1'b0}}, mag};
  end

  // Next accumulator value: clear wins over capture, capture folds the sample in per mode.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (cap_en_i) begin
      case (mode_i)
        MODE_PEAK: acc_d = (mag_ext > acc_q) ? mag_ext : acc_q;
        MODE_AVG:  acc_d = acc_q + sample_ext;
        default:   acc_d = sample_ext;
      endcase
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Only the average is scaled; pass and peak already fit in DATA_W.
  always_comb begin
    if (mode_i == MODE_AVG) begin
      result_o = DATA_W'(acc_q >>> shift_i);
    end else begin
      result_o = DATA_W'(acc_q);
    end
  end

endmodule

// File: rtl/fifo_stream_bridge.sv
// Moves channel-interleaved samples from the input FIFO to the VGA FIFO, reducing
// each channel over 2^k samples. Optional statistics counters are enabled by
// defining FIFO_STREAM_BRIDGE_STATS_EN.
module fifo_stream_bridge
  import fifo_stream_bridge_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int CHANNELS = 2,
  parameter  int MAX_LOG2 = 4,
  localparam int LOG_W    = $clog2(MAX_LOG2 + 1)
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_mode,
  input  logic [LOG_W-1:0]     cfg_log2,
  fifo_stream_bridge_if.master bus,
  output logic                 data_back,
  output logic                 busy
`ifdef FIFO_STREAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]          stat_frames,
  output logic [15:0]          stat_stalls
`endif
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [LOG_W-1:0]  k_q;
  logic [CH_W-1:0]   ch_idx_q, e_idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              data_back_q;

  logic [CNT_W-1:0]  cnt_inc, n_target;
  logic              frame_full, last_write, latch_cfg;
  logic [CHANNELS-1:0] cap_en;
  logic [DATA_W-1:0] lane_result [CHANNELS];

  // Pass mode forces a single-sample frame; other modes clamp k to MAX_LOG2.
  function automatic logic [LOG_W-1:0] eff_log2(input logic [1:0] m, input logic [LOG_W-1:0] r);
    if (decode_mode(m) == MODE_PASS) return '0;
    if (r > LOG_W'(MAX_LOG2))        return LOG_W'(MAX_LOG2);
    return r;
  endfunction

  // Frame bookkeeping: when the sample count hits N, and when the final channel is written.
  always_comb begin
    cnt_inc    = cnt_q + CNT_W'(1);
    n_target   = CNT_W'(1) << k_q;
    frame_full = (ch_idx_q == LAST_CH) && (cnt_inc == n_target);
    last_write = (state_q == S_EMIT) && !bus.out_full && (e_idx_q == LAST_CH);
    latch_cfg  = cfg_enable && ((state_q == S_IDLE) || last_write);
    for (int i = 0; i < CHANNELS; i++) begin
      cap_en[i] = (state_q == S_CAP) && (ch_idx_q == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    fifo_stream_bridge_lane #(
      .DATA_W   (DATA_W),
      .MAX_LOG2 (MAX_LOG2),
      .LOG_W    (LOG_W)
    ) u_lane (
      .clk_i    (clk_clk),
      .rst_i    (reset_reset),
      .cap_en_i (cap_en[g]),
      .clear_i  (last_write),
      .mode_i   (mode_q),
      .shift_i  (k_q),
      .sample_i (bus.in_q),
      .result_o (lane_result[g])
    );
  end

  // State register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stalls simply hold the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_enable) state_d = S_FETCH;
      S_FETCH: if (!bus.in_rdempty) state_d = S_CAP;
      S_CAP:   state_d = frame_full ? S_EMIT : S_FETCH;
      S_EMIT:  if (last_write) state_d = cfg_enable ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO handshakes; write data is only driven while emitting.
  always_comb begin
    bus.in_rdreq  = 1'b0;
    bus.out_wrreq = 1'b0;
    bus.out_data  = '0;
    case (state_q)
      S_FETCH: bus.in_rdreq = !bus.in_rdempty;
      S_EMIT: begin
        bus.out_wrreq = !bus.out_full;
        bus.out_data  = lane_result[e_idx_q];
      end
      default: ;
    endcase
  end

  // Frame config, channel/sample/emit counters and the frame-complete pulse.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mode_q      <= MODE_PASS;
      k_q         <= '0;
      ch_idx_q    <= '0;
      cnt_q       <= '0;
      e_idx_q     <= '0;
      data_back_q <= 1'b0;
    end else begin
      data_back_q <= last_write;
      if (latch_cfg) begin
        mode_q <= decode_mode(cfg_mode);
        k_q    <= eff_log2(cfg_mode, cfg_log2);
      end
      if (last_write) begin
        ch_idx_q <= '0;
        cnt_q    <= '0;
        e_idx_q  <= '0;
      end else begin
        if (state_q == S_CAP) begin
          if (ch_idx_q == LAST_CH) begin
            ch_idx_q <= '0;
            cnt_q    <= cnt_inc;
          end else begin
            ch_idx_q <= ch_idx_q + CH_W'(1);
          end
        end
        if ((state_q == S_EMIT) && !bus.out_full) begin
          e_idx_q <= e_idx_q + CH_W'(1);
        end
      end
    end
  end

  assign data_back = data_back_q;
  assign busy      = (state_q != S_IDLE);

`ifdef FIFO_STREAM_BRIDGE_STATS_EN
  logic [15:0] frames_q, stalls_q;

  // Completed-frame counter (wrapping) and output back-pressure counter (saturating).
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      frames_q <= '0;
      stalls_q <= '0;
    end else begin
      if (data_back_q) frames_q <= frames_q + 16'd1;
      if ((state_q == S_EMIT) && bus.out_full && (stalls_q != 16'hFFFF)) begin
        stalls_q <= stalls_q + 16'd1;
      end
    end
  end

  assign stat_frames = frames_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_stream_bridge.sv
// Directed bench for fifo_stream_bridge: a queue-backed input FIFO, a reference
// reduction model and a per-cycle output comparator.
module tb_fifo_stream_bridge;

  localparam int DATA_W   = 32;
  localparam int CHANNELS = 2;
  localparam int MAX_LOG2 = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfgEnable = 1'b0;
  logic [1:0] cfgMode = 2'd0;
  logic [2:0] cfgLog2 = 3'd0;
  logic       dataBack, busy;

  fifo_stream_bridge_if #(.DATA_W(DATA_W)) bus ();

`ifdef FIFO_STREAM_BRIDGE_STATS_EN
  logic [15:0] statFrames, statStalls;
`endif

  fifo_stream_bridge #(
    .DATA_W   (DATA_W),
    .CHANNELS (CHANNELS),
    .MAX_LOG2 (MAX_LOG2)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset),
    .cfg_enable  (cfgEnable),
    .cfg_mode    (cfgMode),
    .cfg_log2    (cfgLog2),
    .bus         (bus),
    .data_back   (dataBack),
    .busy        (busy)
`ifdef FIFO_STREAM_BRIDGE_STATS_EN
    ,
    .stat_frames (statFrames),
    .stat_stalls (statStalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] fifoQ[$];
  logic [31:0] stimQ[$];
  logic [31:0] expQ[$];
  logic [31:0] obsQ[$];
  int   rdCount = 0;
  int   frameCount = 0;
  int   frameWr = 0;
  logic expDb = 1'b0;
  logic stallEmpty = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference reduction of one channel over the frame currently in stimQ.
  function automatic logic [31:0] modelResult(input logic [1:0] mode, input int log2, input int ch);
    int     k;
    int     n;
    longint acc;
    longint v;
    longint a;
    k   = (log2 > MAX_LOG2) ? MAX_LOG2 : log2;
    n   = (mode == 2'd1 || mode == 2'd2) ? (1 << k) : 1;
    acc = 0;
    for (int j = 0; j < n; j++) begin
      v = longint'($signed(stimQ[j*CHANNELS + ch]));
      if (mode == 2'd1) begin
        a = (v < 0) ? -v : v;
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (a > acc) acc = a;
      end else if (mode == 2'd2) begin
        acc = acc + v;
      end else begin
        acc = v;
      end
    end
    if (mode == 2'd2) acc = acc >>> k;
    return acc[31:0];
  endfunction

  // Input FIFO: data appears the cycle after a read request, empty flag updates after each edge.
  initial begin : fifoModel
    logic take;
    bus.in_q       = '0;
    bus.in_rdempty = 1'b1;
    forever begin
      @(negedge clk);
      take = bus.in_rdreq;
      @(posedge clk);
      #1;
      if (take && fifoQ.size() > 0) bus.in_q = fifoQ.pop_front();
      bus.in_rdempty = (fifoQ.size() == 0) || stallEmpty;
    end
  end

  // Per-cycle comparison of handshakes, write data and frame pulse against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("rdreq while empty", {31'd0, bus.in_rdreq & bus.in_rdempty}, 32'd0);
      checkOutput("wrreq while full", {31'd0, bus.out_wrreq & bus.out_full}, 32'd0);
      checkOutput("data_back", {31'd0, dataBack}, {31'd0, expDb});
      expDb = 1'b0;
      if (bus.in_rdreq) rdCount++;
      if (dataBack) frameCount++;
      if (bus.out_wrreq) begin
        obsQ.push_back(bus.out_data);
        if (expQ.size() == 0) begin
          failNow("write with no expected result");
        end else begin
          checkOutput("out_data vs model", bus.out_data, expQ.pop_front());
        end
        frameWr++;
        if (frameWr == CHANNELS) begin
          frameWr = 0;
          expDb   = 1'b1;
        end
      end
    end
  end

  // Queue a frame and its expected results, then pulse cfg_enable for one frame.
  task automatic applyStimulus(input logic [1:0] mode, input int log2);
    for (int c = 0; c < CHANNELS; c++) expQ.push_back(modelResult(mode, log2, c));
    foreach (stimQ[i]) fifoQ.push_back(stimQ[i]);
    stimQ.delete();
    obsQ.delete();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) failNow("timeout waiting for idle");
    @(negedge clk);
    cfgMode   = mode;
    cfgLog2   = 3'(log2);
    cfgEnable = 1'b1;
    @(posedge clk);
    #1;
    cfgEnable = 1'b0;
  endtask

  task automatic waitFrame(input int target);
    for (int i = 0; i < 500 && frameCount < target; i++) @(negedge clk);
    if (frameCount < target) failNow("timeout waiting for data_back");
  endtask

  task automatic waitReads(input int target);
    for (int i = 0; i < 500 && rdCount < target; i++) @(negedge clk);
    if (rdCount < target) failNow("timeout waiting for reads");
  endtask

  task automatic checkWrites(input string tag, input logic [31:0] a, input logic [31:0] b);
    checkOutput({tag, " write count"}, 32'(obsQ.size()), 32'd2);
    checkOutput({tag, " ch0"}, (obsQ.size() > 0) ? obsQ[0] : 32'hDEAD_BEEF, a);
    checkOutput({tag, " ch1"}, (obsQ.size() > 1) ? obsQ[1] : 32'hDEAD_BEEF, b);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " in_rdreq"}, {31'd0, bus.in_rdreq}, 32'd0);
    checkOutput({tag, " out_wrreq"}, {31'd0, bus.out_wrreq}, 32'd0);
    checkOutput({tag, " out_data"}, bus.out_data, 32'd0);
    checkOutput({tag, " data_back"}, {31'd0, dataBack}, 32'd0);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Directed test sequence.
  initial begin : mainSeq
    int base;
    int frames;
    bus.out_full = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] pass mode, two samples");
    stimQ = '{32'h11, 32'h22};
    applyStimulus(2'd0, 0);
    waitFrame(1);
    repeat (2) @(negedge clk);
    checkWrites("pass", 32'h11, 32'h22);
    checkOutput("pass frames", 32'(frameCount), 32'd1);

    $display("[TB] average k=2");
    base  = rdCount;
    stimQ = '{32'd4, 32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFF, 32'd12, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFFF};
    applyStimulus(2'd2, 2);
    waitFrame(2);
    checkWrites("avg", 32'd10, 32'hFFFF_FFFF);
    checkOutput("avg rdreq pulses", 32'(rdCount - base), 32'd8);

    $display("[TB] peak k=1");
    stimQ = '{32'hFFFF_FFFB, 32'h8000_0000, 32'd3, 32'd1};
    applyStimulus(2'd1, 1);
    waitFrame(3);
    checkWrites("peak", 32'd5, 32'h7FFF_FFFF);

    $display("[TB] mode 3 ignores k");
    base  = rdCount;
    stimQ = '{32'h0A, 32'h0B};
    applyStimulus(2'd3, 3);
    waitFrame(4);
    checkWrites("mode3", 32'h0A, 32'h0B);
    checkOutput("mode3 rdreq pulses", 32'(rdCount - base), 32'd2);

    $display("[TB] average with k clamped to MAX_LOG2");
    base = rdCount;
    for (int j = 0; j < 16; j++) begin
      stimQ.push_back(32'(j));
      stimQ.push_back(32'h7FFF_FFFF);
    end
    applyStimulus(2'd2, 7);
    waitFrame(5);
    checkWrites("clamp", 32'd7, 32'h7FFF_FFFF);
    checkOutput("clamp rdreq pulses", 32'(rdCount - base), 32'd32);

    $display("[TB] output back-pressure");
    @(negedge clk);
    bus.out_full = 1'b1;
    base  = rdCount;
    stimQ = '{32'h77, 32'h88};
    applyStimulus(2'd0, 0);
    waitReads(base + 2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("full out_wrreq", {31'd0, bus.out_wrreq}, 32'd0);
      checkOutput("full out_data hold", bus.out_data, 32'h77);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_full = 1'b0;
    waitFrame(6);
    checkWrites("full", 32'h77, 32'h88);

    $display("[TB] input stall mid-frame");
    base  = rdCount;
    stimQ = '{32'd4, 32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFF, 32'd12, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFFF};
    applyStimulus(2'd2, 2);
    waitReads(base + 3);
    stallEmpty = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("stall in_rdreq", {31'd0, bus.in_rdreq}, 32'd0);
    end
    stallEmpty = 1'b0;
    waitFrame(7);
    checkWrites("stall", 32'd10, 32'hFFFF_FFFF);
    checkOutput("stall rdreq pulses", 32'(rdCount - base), 32'd8);

    $display("[TB] reset during emit");
    stimQ = '{32'h33, 32'h44};
    applyStimulus(2'd0, 0);
    for (int i = 0; i < 100 && !bus.out_wrreq; i++) @(negedge clk);
    if (!bus.out_wrreq) failNow("timeout waiting for first write");
    @(posedge clk);
    #1;
    bus.out_full = 1'b1;
    reset = 1'b1;
    #1;
    checkAllZero("mid-emit reset");
    expQ.delete();
    frameWr = 0;
    expDb   = 1'b0;
    frames  = frameCount;
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    bus.out_full = 1'b0;
    stimQ = '{32'h55, 32'h66};
    applyStimulus(2'd0, 0);
    waitFrame(frames + 1);
    repeat (2) @(negedge clk);
    checkWrites("post-reset", 32'h55, 32'h66);
    checkOutput("post-reset frames", 32'(frameCount - frames), 32'd1);

`ifdef FIFO_STREAM_BRIDGE_STATS_EN
    checkOutput("stat_frames", {16'd0, statFrames}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #400000;
    failNow("global timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
